// File: rtl/axi_lite_cordic_slave.sv
`default_nettype none
// ============================================================================
// Module   : axi_lite_cordic_slave
// Purpose  : Reduced AXI-lite responder (no WSTRB/BRESP/RRESP/PROT) that
//            exposes the CORDIC core's register file: CTRL, STATUS, ARG0,
//            ARG1, RES0 and RES1. Issues a one-cycle start pulse to the core
//            and captures its results together with a sticky done flag.
// Ports    : ACLK/ARESETN        - clock, asynchronous active-low reset
//            S_AW*/S_W*/S_B*     - write address, write data, write response
//            S_AR*/S_R*          - read address, read data
//            core_start          - one-cycle start pulse to the core
//            core_arg0/1         - live copies of ARG0/ARG1
//            core_done/res0/res1 - completion pulse and results from the core
// Revision : 1.0 - initial release
// ============================================================================
module axi_lite_cordic_slave #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic [ADDR_WIDTH-1:0] S_AWADDR,
  input  logic                  S_AWVALID,
  output logic                  S_AWREADY,
  input  logic [DATA_WIDTH-1:0] S_WDATA,
  input  logic                  S_WVALID,
  output logic                  S_WREADY,
  output logic                  S_BVALID,
  input  logic                  S_BREADY,
  input  logic [ADDR_WIDTH-1:0] S_ARADDR,
  input  logic                  S_ARVALID,
  output logic                  S_ARREADY,
  output logic [DATA_WIDTH-1:0] S_RDATA,
  output logic                  S_RVALID,
  input  logic                  S_RREADY,
  output logic                  core_start,
  output logic [DATA_WIDTH-1:0] core_arg0,
  output logic [DATA_WIDTH-1:0] core_arg1,
  input  logic                  core_done,
  input  logic [DATA_WIDTH-1:0] core_res0,
  input  logic [DATA_WIDTH-1:0] core_res1
);

  // Word offsets (ADDR[11:2])
  localparam logic [9:0] OFF_CTRL   = 10'h000;
  localparam logic [9:0] OFF_STATUS = 10'h001;
  localparam logic [9:0] OFF_ARG0   = 10'h002;
  localparam logic [9:0] OFF_ARG1   = 10'h003;
  localparam logic [9:0] OFF_RES0   = 10'h004;
  localparam logic [9:0] OFF_RES1   = 10'h005;

  // Registered state
  logic                  ready_en_q, ready_en_d;
  logic                  aw_held_q,  aw_held_d;
  logic [9:0]            aw_off_q,   aw_off_d;
  logic                  w_held_q,   w_held_d;
  logic [DATA_WIDTH-1:0] w_data_q,   w_data_d;
  logic                  bvalid_q,   bvalid_d;
  logic                  rvalid_q,   rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q,    rdata_d;
  logic [DATA_WIDTH-1:0] arg0_q,     arg0_d;
  logic [DATA_WIDTH-1:0] arg1_q,     arg1_d;
  logic [DATA_WIDTH-1:0] res0_q,     res0_d;
  logic [DATA_WIDTH-1:0] res1_q,     res1_d;
  logic                  busy_q,     busy_d;
  logic                  done_q,     done_d;
  logic                  start_q,    start_d;

  // Combinational helpers
  logic                  aw_hs, w_hs, ar_hs, commit;
  logic [9:0]            wr_off, rd_off;
  logic [DATA_WIDTH-1:0] wr_data, rd_mux;

  // Address bits outside the decoded window are intentionally ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{S_AWADDR[ADDR_WIDTH-1:12], S_AWADDR[1:0],
                              S_ARADDR[ADDR_WIDTH-1:12], S_ARADDR[1:0]};

  // ready_en_q is 0 while in reset, so every READY is low during reset and
  // only rises one cycle after release.
  assign S_AWREADY  = ready_en_q && !aw_held_q && !bvalid_q;
  assign S_WREADY   = ready_en_q && !w_held_q  && !bvalid_q;
  assign S_ARREADY  = ready_en_q && !rvalid_q;
  assign S_BVALID   = bvalid_q;
  assign S_RVALID   = rvalid_q;
  assign S_RDATA    = rdata_q;
  assign core_start = start_q;
  assign core_arg0  = arg0_q;
  assign core_arg1  = arg1_q;

  assign aw_hs = S_AWVALID && S_AWREADY;
  assign w_hs  = S_WVALID  && S_WREADY;
  assign ar_hs = S_ARVALID && S_ARREADY;

  // A write commits on the edge where both halves are available, either
  // already held or handshaking right now.
  assign commit  = (aw_held_q || aw_hs) && (w_held_q || w_hs);
  assign wr_off  = aw_held_q ? aw_off_q : S_AWADDR[11:2];
  assign wr_data = w_held_q  ? w_data_q : S_WDATA;
  assign rd_off  = S_ARADDR[11:2];

  // Read mux uses pre-edge register values, so a read colliding with a
  // write to the same register returns the old contents.
  always_comb begin
    rd_mux = '0;
    case (rd_off)
      OFF_STATUS: rd_mux = {{(DATA_WIDTH-2){1'b0}}, done_q, busy_q};
      OFF_ARG0:   rd_mux = arg0_q;
      OFF_ARG1:   rd_mux = arg1_q;
      OFF_RES0:   rd_mux = res0_q;
      OFF_RES1:   rd_mux = res1_q;
      default:    rd_mux = '0;
    endcase
  end

  always_comb begin
    ready_en_d = 1'b1;
    aw_held_d  = aw_held_q;
    aw_off_d   = aw_off_q;
    w_held_d   = w_held_q;
    w_data_d   = w_data_q;
    bvalid_d   = bvalid_q;
    rvalid_d   = rvalid_q;
    rdata_d    = rdata_q;
    arg0_d     = arg0_q;
    arg1_d     = arg1_q;
    res0_d     = res0_q;
    res1_d     = res1_q;
    busy_d     = busy_q;
    done_d     = done_q;
    start_d    = 1'b0;

    // Write channel
    if (aw_hs) begin
      aw_held_d = 1'b1;
      aw_off_d  = S_AWADDR[11:2];
    end
    if (w_hs) begin
      w_held_d = 1'b1;
      w_data_d = S_WDATA;
    end
    if (bvalid_q && S_BREADY) begin
      bvalid_d = 1'b0;
    end
    if (commit) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      case (wr_off)
        OFF_CTRL: begin
          // busy_q is the pre-edge value: a start arriving with core_done
          // in the same cycle is ignored.
          if (wr_data[0] && !busy_q) begin
            start_d = 1'b1;
            busy_d  = 1'b1;
            done_d  = 1'b0;
          end
        end
        OFF_ARG0: arg0_d = wr_data;
        OFF_ARG1: arg1_d = wr_data;
        default:  ;
      endcase
    end

    // Core completion (start requires !busy_q, so the two never collide)
    if (core_done && busy_q) begin
      res0_d = core_res0;
      res1_d = core_res1;
      busy_d = 1'b0;
      done_d = 1'b1;
    end

    // Read channel
    if (rvalid_q && S_RREADY) begin
      rvalid_d = 1'b0;
    end
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_mux;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      ready_en_q <= 1'b0;
      aw_held_q  <= 1'b0;
      aw_off_q   <= '0;
      w_held_q   <= 1'b0;
      w_data_q   <= '0;
      bvalid_q   <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      arg0_q     <= '0;
      arg1_q     <= '0;
      res0_q     <= '0;
      res1_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      start_q    <= 1'b0;
    end else begin
      ready_en_q <= ready_en_d;
      aw_held_q  <= aw_held_d;
      aw_off_q   <= aw_off_d;
      w_held_q   <= w_held_d;
      w_data_q   <= w_data_d;
      bvalid_q   <= bvalid_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      arg0_q     <= arg0_d;
      arg1_q     <= arg1_d;
      res0_q     <= res0_d;
      res1_q     <= res1_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      start_q    <= start_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_cordic_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_lite_cordic_slave
// Purpose  : Directed self-checking bench for axi_lite_cordic_slave.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_lite_cordic_slave;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] awaddr = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [31:0] araddr = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic        rvalid;
  logic        rready = 1'b0;
  logic        core_start;
  logic [31:0] core_arg0, core_arg1;
  logic        core_done = 1'b0;
  logic [31:0] core_res0 = '0, core_res1 = '0;

  int n_pass = 0;
  int n_total = 0;
  int start_count = 0;

  axi_lite_cordic_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .ACLK(clk), .ARESETN(rst_n),
    .S_AWADDR(awaddr), .S_AWVALID(awvalid), .S_AWREADY(awready),
    .S_WDATA(wdata), .S_WVALID(wvalid), .S_WREADY(wready),
    .S_BVALID(bvalid), .S_BREADY(bready),
    .S_ARADDR(araddr), .S_ARVALID(arvalid), .S_ARREADY(arready),
    .S_RDATA(rdata), .S_RVALID(rvalid), .S_RREADY(rready),
    .core_start(core_start), .core_arg0(core_arg0), .core_arg1(core_arg1),
    .core_done(core_done), .core_res0(core_res0), .core_res1(core_res1)
  );

  always #5 clk = ~clk;

  // core_start is high for whole cycles; count once per cycle mid-period.
  always @(negedge clk) if (core_start === 1'b1) start_count++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d);
    logic aw_ok = 1'b0, w_ok = 1'b0, b_ok = 1'b0;
    awaddr = a; wdata = d; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    for (int i = 0; i < 20 && !(aw_ok && w_ok); i++) begin
      if (awready) aw_ok = 1'b1;
      if (wready)  w_ok  = 1'b1;
      tick();
      if (aw_ok) awvalid = 1'b0;
      if (w_ok)  wvalid  = 1'b0;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    for (int i = 0; i < 20 && !b_ok; i++) begin
      if (bvalid) b_ok = 1'b1;
      tick();
    end
    check("wr_timeout", {31'd0, !(aw_ok && w_ok && b_ok)}, 32'd0);
  endtask

  task automatic axi_read(input logic [31:0] a, output logic [31:0] d);
    logic ar_ok = 1'b0, r_ok = 1'b0;
    d = 'x;
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    for (int i = 0; i < 20 && !ar_ok; i++) begin
      if (arready) ar_ok = 1'b1;
      tick();
    end
    arvalid = 1'b0;
    for (int i = 0; i < 20 && !r_ok; i++) begin
      if (rvalid) begin
        r_ok = 1'b1;
        d = rdata;
      end
      tick();
    end
    check("rd_timeout", {31'd0, !(ar_ok && r_ok)}, 32'd0);
  endtask

  logic [31:0] rd;

  initial begin
    // ---------------- reset state ----------------
    repeat (3) @(posedge clk);
    #1;
    check("rst_awready", {31'd0, awready}, 32'd0);
    check("rst_wready",  {31'd0, wready},  32'd0);
    check("rst_arready", {31'd0, arready}, 32'd0);
    check("rst_bvalid",  {31'd0, bvalid},  32'd0);
    check("rst_rvalid",  {31'd0, rvalid},  32'd0);
    check("rst_start",   {31'd0, core_start}, 32'd0);
    check("rst_rdata",   rdata, 32'd0);
    rst_n = 1'b1;
    tick();
    check("post_rst_awready", {31'd0, awready}, 32'd1);
    check("post_rst_arready", {31'd0, arready}, 32'd1);

    // ---------------- 1: AW+W same cycle ----------------
    awaddr = 32'h4000_0008; wdata = 32'h1234_5678;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    check("t1_bvalid_next", {31'd0, bvalid}, 32'd1);
    check("t1_arg0", core_arg0, 32'h1234_5678);
    tick();
    check("t1_bvalid_drop", {31'd0, bvalid}, 32'd0);
    axi_read(32'h4000_0008, rd);
    check("t1_rd_arg0", rd, 32'h1234_5678);

    // ---------------- 2: W before AW, BREADY held low ----------------
    bready = 1'b0;
    wdata = 32'h0000_00AA; wvalid = 1'b1;
    check("t2_wready", {31'd0, wready}, 32'd1);
    tick();
    wvalid = 1'b0;
    check("t2_wready_held", {31'd0, wready}, 32'd0);
    tick();
    tick();
    check("t2_no_commit", core_arg1, 32'd0);
    check("t2_no_bvalid", {31'd0, bvalid}, 32'd0);
    awaddr = 32'h4000_000C; awvalid = 1'b1;
    check("t2_awready", {31'd0, awready}, 32'd1);
    tick();
    awvalid = 1'b0;
    check("t2_arg1", core_arg1, 32'h0000_00AA);
    for (int i = 0; i < 4; i++) begin
      check("t2_hold", {29'd0, bvalid, awready, wready}, 32'b100);
      tick();
    end
    bready = 1'b1;
    tick();
    check("t2_after_b", {29'd0, bvalid, awready, wready}, 32'b011);

    // ---------------- 3: start, busy, done, results ----------------
    awaddr = 32'h4000_0000; wdata = 32'h1;
    awvalid = 1'b1; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    check("t3_start_hi", {31'd0, core_start}, 32'd1);
    tick();
    check("t3_start_lo", {31'd0, core_start}, 32'd0);
    check("t3_start_count", start_count, 32'd1);
    axi_read(32'h4000_0004, rd);
    check("t3_status_busy", rd, 32'h1);
    axi_read(32'h4000_0000, rd);
    check("t3_ctrl_rd0", rd, 32'h0);
    core_res0 = 32'h0000_4000; core_res1 = 32'hFFFF_C000; core_done = 1'b1;
    tick();
    core_done = 1'b0;
    axi_read(32'h4000_0004, rd);
    check("t3_status_done", rd, 32'h2);
    axi_read(32'h4000_0010, rd);
    check("t3_res0", rd, 32'h0000_4000);
    axi_read(32'h4000_0014, rd);
    check("t3_res1", rd, 32'hFFFF_C000);

    // ---------------- 4: starts while busy are ignored ----------------
    axi_write(32'h4000_0000, 32'h1);
    check("t4_second_start", start_count, 32'd2);
    axi_write(32'h4000_0000, 32'h1);
    check("t4_busy_ignored", start_count, 32'd2);
    awaddr = 32'h4000_0000; wdata = 32'h1; awvalid = 1'b1; wvalid = 1'b1;
    core_res0 = 32'h1111_1111; core_res1 = 32'h2222_2222; core_done = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0; core_done = 1'b0;
    check("t4_coincide_ack", {31'd0, bvalid}, 32'd1);
    tick();
    tick();
    check("t4_coincide_ignored", start_count, 32'd2);
    axi_read(32'h4000_0004, rd);
    check("t4_status", rd, 32'h2);
    axi_read(32'h4000_0010, rd);
    check("t4_res0", rd, 32'h1111_1111);

    // ---------------- 5: unmapped read/write ----------------
    rready = 1'b0;
    araddr = 32'h4000_0040; arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("t5_rvalid_hold", {31'd0, rvalid}, 32'd1);
      check("t5_rdata_zero", rdata, 32'd0);
      check("t5_arready_lo", {31'd0, arready}, 32'd0);
      if (i < 2) tick();
    end
    rready = 1'b1;
    tick();
    check("t5_rvalid_drop", {31'd0, rvalid}, 32'd0);
    axi_write(32'h4000_003C, 32'hDEAD_BEEF);
    axi_read(32'h4000_0008, rd);
    check("t5_arg0_kept", rd, 32'h1234_5678);
    axi_read(32'h4000_000C, rd);
    check("t5_arg1_kept", rd, 32'h0000_00AA);

    // ---------------- 6: reset mid-transaction ----------------
    bready = 1'b0; rready = 1'b0;
    awaddr = 32'h4000_0008; wdata = 32'h5555_5555; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 32'h4000_0010; arvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    check("t6_pre_valids", {30'd0, bvalid, rvalid}, 32'b11);
    check("t6_pre_rdata", rdata, 32'h1111_1111);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_valids_drop", {30'd0, bvalid, rvalid}, 32'b00);
    check("t6_readys_drop", {29'd0, awready, wready, arready}, 32'b000);
    check("t6_arg0_zero", core_arg0, 32'd0);
    check("t6_arg1_zero", core_arg1, 32'd0);
    check("t6_rdata_zero", rdata, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t6_no_stale", {30'd0, bvalid, rvalid}, 32'b00);
    end
    axi_read(32'h4000_0010, rd);
    check("t6_res0_zero", rd, 32'd0);
    axi_read(32'h4000_0004, rd);
    check("t6_status_zero", rd, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/axi_lite_cordic_slave.md
Name: axi_lite_cordic_slave

Overview:
AXI-lite responder that terminates the interconnect's slave-0 port (window 0x4000_0000–0x4000_0FFF) and exposes a small register file to the CORDIC core. It accepts RISC-V writes and reads, latches operands, and issues a one-cycle start pulse to the core. It captures results and a sticky done flag on core completion. It uses the same reduced AXI-lite signal set as the interconnect: no WSTRB, BRESP, RRESP, or PROT.

Parameters:
ADDR_WIDTH, 32, width of AWADDR/ARADDR
DATA_WIDTH, 32, width of WDATA/RDATA and all registers

Ports:
ACLK  in  1  clock, all logic on rising edge
ARESETN  in  1  asynchronous active-low reset
S_AWADDR  in  ADDR_WIDTH  write address
S_AWVALID  in  1  write address valid
S_AWREADY  out  1  write address ready
S_WDATA  in  DATA_WIDTH  write data
S_WVALID  in  1  write data valid
S_WREADY  out  1  write data ready
S_BVALID  out  1  write response valid
S_BREADY  in  1  write response ready
S_ARADDR  in  ADDR_WIDTH  read address
S_ARVALID  in  1  read address valid
S_ARREADY  out  1  read address ready
S_RDATA  out  DATA_WIDTH  read data
S_RVALID  out  1  read data valid
S_RREADY  in  1  read data ready
core_start  out  1  one-cycle start pulse to CORDIC
core_arg0  out  DATA_WIDTH  ARG0 register contents
core_arg1  out  DATA_WIDTH  ARG1 register contents
core_done  in  1  one-cycle completion pulse from CORDIC
core_res0  in  DATA_WIDTH  result 0, valid when core_done=1
core_res1  in  DATA_WIDTH  result 1, valid when core_done=1

Behaviour:
- Register offsets decode on ADDR[11:2]; ADDR[1:0] is ignored.
  - 0x00 CTRL: write bit0=1 starts the core; reads return 0.
  - 0x04 STATUS: read-only; bit0=busy, bit1=done.
  - 0x08 ARG0: read/write.
  - 0x0C ARG1: read/write.
  - 0x10 RES0: read-only.
  - 0x14 RES1: read-only.
  - Any other offset reads 0. Writes to it are completed (BVALID issued) with no effect.
- Reset (ARESETN=0, asynchronous):
  - All READY and VALID outputs go to 0.
  - S_RDATA, ARG0, ARG1, RES0 and RES1 go to 0.
  - busy, done and core_start go to 0.
  - Any pending AW/W latches and in-flight responses are discarded. No BVALID or RVALID appears after reset release.
- Write channel:
  - AW and W are independent and may arrive in either order or in the same cycle.
  - S_AWREADY=1 when no address is latched and S_BVALID=0. S_WREADY=1 when no data is latched and S_BVALID=0.
  - On handshake the address or data is latched into a holding register.
  - When both are held, the register write commits on that edge. S_BVALID rises the following cycle and both holding flags clear.
  - Minimum latency: AW+W in cycle N gives commit at edge N+1 and BVALID=1 in cycle N+1.
  - S_BVALID holds until S_BVALID&&S_BREADY. After that, READY signals may reassert the next cycle. There is no back-to-back overlap.
- Read channel:
  - S_ARREADY=1 when S_RVALID=0.
  - On handshake, S_RDATA is registered from the current register value and S_RVALID=1 the next cycle.
  - S_RDATA and S_RVALID stay stable until S_RREADY is sampled high. S_RVALID then drops.
- Read and write are fully independent. If a read and a write commit to the same register on the same edge, the read returns the pre-write value.
- Start and completion:
  - A CTRL write with bit0=1 while busy=0 drives core_start=1 for exactly one cycle (the cycle after commit). It also sets busy=1 and clears done.
  - A CTRL write while busy=1 is ignored but still acknowledged. busy is evaluated as its registered value before the edge, so a start coinciding with core_done is ignored.
  - core_done=1: RES0 and RES1 capture core_res0 and core_res1, busy goes to 0, and done goes to 1 (sticky until the next accepted start).
  - core_done while busy=0 is ignored.
- core_arg0 and core_arg1 are continuous copies of ARG0 and ARG1. Writes to ARG0/ARG1 during busy update them immediately; the core must sample them on core_start.

Test Plan:
- Reset, then AW(0x4000_0008) and W(0x1234_5678) in the same cycle, then read 0x08 -> BVALID one cycle later; RDATA=0x1234_5678; core_arg0=0x1234_5678.
- W(0xAA) issued 3 cycles before AW(0x0C), with BREADY held low 4 cycles -> no commit until AW arrives; BVALID stays high; AWREADY/WREADY stay 0 until the B handshake.
- Write CTRL=1, then pulse core_done with res0=0x0000_4000 and res1=0xFFFF_C000 -> one-cycle core_start; STATUS=0x1 during busy; STATUS=0x2 after done; RES0/RES1 read back the captured values.
- CTRL=1 written while busy, and again coinciding with core_done -> no second core_start; busy clears; done=1.
- Read 0x40 and write 0x3C, with RREADY held low 2 cycles -> RDATA=0 held stable; write acknowledged with no register change.
- Assert ARESETN=0 mid-transaction with BVALID and RVALID high -> both drop immediately; registers are 0; no stale response after release.
